hack_rom_loader: RTL and testbench

HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

---
 rtl/hack_rom_loader.sv | 140 ++++++++++++++
 tb/tb_hack_rom_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: streams a byte-serial Hack image into ROM, holding the CPU in reset until it is loaded.
// Define HACK_LOADER_CHECKSUM_EN to expect and verify a 16-bit checksum trailer word.
module hack_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_xrst,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = ADDR_W + 1;
  typedef enum logic [3:0] {HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, SUM_HI, SUM_LO, DONE, ERROR} state_t;
`ifdef HACK_LOADER_CHECKSUM_EN
  localparam state_t LAST = SUM_HI;
  logic [15:0] sum_q, sum_d;
`else
  localparam state_t LAST = DONE;
`endif
  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       n_q, n_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              in_ready_q, in_ready_d, rom_we_q, rom_we_d, cpu_xrst_q, cpu_xrst_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              acc;
  always_comb begin
    acc = in_valid && in_ready_q;
    state_d = state_q;
    hi_d = hi_q;
    n_d = n_q;
    idx_d = idx_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
`ifdef HACK_LOADER_CHECKSUM_EN
    sum_d = sum_q;
`endif
    case (state_q)
      HDR_HI: if (acc) begin
        hi_d = in_data;
        state_d = HDR_LO;
      end
      HDR_LO: if (acc) begin
        n_d = {hi_q, in_data};
        state_d = (n_d == 16'd0) ? LAST : (32'(n_d) > (32'd1 << ADDR_W)) ? ERROR : DAT_HI;
      end
      DAT_HI: if (acc) begin
        hi_d = in_data;
        state_d = DAT_LO;
      end
      DAT_LO: if (acc) begin
        wdata_d = {hi_q, in_data};
        addr_d = idx_q[ADDR_W-1:0];
        state_d = WRITE;
`ifdef HACK_LOADER_CHECKSUM_EN
        sum_d = sum_q + wdata_d;
`endif
      end
      WRITE: begin
        idx_d = idx_q + CW'(1);
        state_d = (32'(idx_d) < 32'(n_q)) ? DAT_HI : LAST;
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      SUM_HI: if (acc) begin
        hi_d = in_data;
        state_d = SUM_LO;
      end
      SUM_LO: if (acc) state_d = ({hi_q, in_data} == sum_q) ? DONE : ERROR;
`endif
      DONE, ERROR: if (start) begin
        idx_d = '0;
`ifdef HACK_LOADER_CHECKSUM_EN
        sum_d = '0;
`endif
        state_d = HDR_HI;
      end
      default: state_d = HDR_HI;
    endcase
    // Outputs are decoded from the next state so they are registered yet aligned with it
    in_ready_d = state_d inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO};
    rom_we_d = state_d == WRITE;
    cpu_xrst_d = state_d == DONE;
    busy_d = !(state_d inside {DONE, ERROR});
    done_d = state_d == DONE;
    error_d = state_d == ERROR;
  end
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= HDR_HI;
      hi_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      in_ready_q <= 1'b1;
      rom_we_q <= 1'b0;
      cpu_xrst_q <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      error_q <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      n_q <= n_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      in_ready_q <= in_ready_d;
      rom_we_q <= rom_we_d;
      cpu_xrst_q <= cpu_xrst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
  assign in_ready = in_ready_q;
  assign rom_we = rom_we_q;
  assign rom_addr = addr_q;
  assign rom_wdata = wdata_q;
  assign cpu_xrst = cpu_xrst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: directed checks of the loader, checksum disabled, on a 15-bit and a 4-bit ROM sharing one stream.
module tb_hack_rom_loader;
  logic clk = 0, xrst = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 8'h00;
  logic in_ready_b, rom_we_b, cpu_xrst_b, busy_b, done_b, error_b;
  logic [14:0] rom_addr_b;
  logic [15:0] rom_wdata_b;
  logic in_ready_s, rom_we_s, cpu_xrst_s, busy_s, done_s, error_s;
  logic [3:0] rom_addr_s;
  logic [15:0] rom_wdata_s;
  int vec = 0, errs = 0;
  logic [30:0] wq_b[$];
  logic [19:0] wq_s[$];

  hack_rom_loader #(.ADDR_W(15)) dut_b (.clk(clk), .xrst(xrst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_b), .rom_we(rom_we_b), .rom_addr(rom_addr_b),
    .rom_wdata(rom_wdata_b), .cpu_xrst(cpu_xrst_b), .busy(busy_b), .done(done_b), .error(error_b));
  hack_rom_loader #(.ADDR_W(4)) dut_s (.clk(clk), .xrst(xrst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_s), .rom_we(rom_we_s), .rom_addr(rom_addr_s),
    .rom_wdata(rom_wdata_s), .cpu_xrst(cpu_xrst_s), .busy(busy_s), .done(done_s), .error(error_s));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_we_b) wq_b.push_back({rom_addr_b, rom_wdata_b});
    if (rom_we_s) wq_s.push_back({rom_addr_s, rom_wdata_s});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1;
    in_data = b;
    while (!in_ready_b && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 0;
    in_data = 8'h5A;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready_b), 32'd1);
    chk({tag, "_rom_we"}, 32'(rom_we_b), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr_b), 32'd0);
    chk({tag, "_rom_wdata"}, 32'(rom_wdata_b), 32'd0);
    chk({tag, "_cpu_xrst"}, 32'(cpu_xrst_b), 32'd0);
    chk({tag, "_flags"}, {29'd0, busy_b, done_b, error_b}, 32'd4);
    chk({tag, "_flags_s"}, {29'd0, busy_s, done_s, error_s}, 32'd4);
  endtask

  initial begin
    @(negedge clk);
    chk_reset("reset");
    xrst = 1;
    @(negedge clk);
    // two-word image
    send_word(16'h0002, 0);
    send_byte(8'hEC, 0);
    send_byte(8'h10, 0);
    chk("w0_we", 32'(rom_we_b), 32'd1);
    chk("w0_addr", 32'(rom_addr_b), 32'h0);
    chk("w0_data", 32'(rom_wdata_b), 32'hEC10);
    chk("w0_ready", 32'(in_ready_b), 32'd0);
    chk("w0_cpu_xrst", 32'(cpu_xrst_b), 32'd0);
    send_byte(8'hE3, 0);
    send_byte(8'h08, 0);
    chk("w1_we", 32'(rom_we_b), 32'd1);
    chk("w1_addr", 32'(rom_addr_b), 32'h1);
    chk("w1_data", 32'(rom_wdata_b), 32'hE308);
    @(negedge clk);
    chk("a_done", {29'd0, busy_b, done_b, error_b}, 32'd2);
    chk("a_cpu_xrst", 32'(cpu_xrst_b), 32'd1);
    chk("a_we_low", 32'(rom_we_b), 32'd0);
    chk("a_addr_hold", 32'(rom_addr_b), 32'h1);
    chk("a_ready_low", 32'(in_ready_b), 32'd0);
    chk("a_done_s", 32'(done_s), 32'd1);
    chk("a_nwrites", wq_b.size(), 32'd2);
    chk("a_wr0", 32'(wq_b[0]), {1'b0, 15'd0, 16'hEC10});
    chk("a_wr1", 32'(wq_b[1]), {1'b0, 15'd1, 16'hE308});
    // bytes offered while not ready are ignored
    in_valid = 1;
    in_data = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 0;
    chk("idle_done", 32'(done_b), 32'd1);
    chk("idle_nwrites", wq_b.size(), 32'd2);
    pulse_start();
    chk("restart_flags", {29'd0, busy_b, done_b, error_b}, 32'd4);
    chk("restart_cpu_xrst", 32'(cpu_xrst_b), 32'd0);
    chk("restart_ready", 32'(in_ready_b), 32'd1);
    // empty image
    wq_b.delete();
    send_word(16'h0000, 0);
    chk("empty_done", 32'(done_b), 32'd1);
    chk("empty_cpu_xrst", 32'(cpu_xrst_b), 32'd1);
    chk("empty_nwrites", wq_b.size(), 32'd0);
    pulse_start();
    // oversize count on both ROMs
    send_word(16'h8001, 0);
    chk("over_flags", {29'd0, busy_b, done_b, error_b}, 32'd1);
    chk("over_error_s", 32'(error_s), 32'd1);
    chk("over_cpu_xrst", 32'(cpu_xrst_b), 32'd0);
    chk("over_ready", 32'(in_ready_b), 32'd0);
    chk("over_nwrites", wq_b.size(), 32'd0);
    pulse_start();
    chk("err_restart", {29'd0, busy_b, done_b, error_b}, 32'd4);
    // fill the 16-word ROM; a start mid-load must be ignored
    wq_s.delete();
    wq_b.delete();
    send_word(16'h0010, 0);
    send_byte(8'h10, 0);
    pulse_start();
    send_byte(8'h00, 0);
    for (int i = 1; i < 16; i++) send_word(16'h1000 + 16'(i), 0);
    chk("full_last_addr", 32'(rom_addr_s), 32'hF);
    chk("full_last_data", 32'(rom_wdata_s), 32'h100F);
    @(negedge clk);
    chk("full_done_s", {29'd0, busy_s, done_s, error_s}, 32'd2);
    chk("full_done_b", 32'(done_b), 32'd1);
    chk("full_addr_nowrap", 32'(rom_addr_s), 32'hF);
    chk("full_nwrites", wq_s.size(), 32'd16);
    chk("full_wr0", 32'(wq_s[0]), {12'd0, 4'h0, 16'h1000});
    chk("full_wr15", 32'(wq_s[15]), {12'd0, 4'hF, 16'h100F});
    pulse_start();
    // largest legal count for the 15-bit ROM, then reset mid-load
    wq_b.delete();
    send_word(16'h8000, 0);
    chk("max_flags_b", {29'd0, busy_b, done_b, error_b}, 32'd4);
    chk("max_ready_b", 32'(in_ready_b), 32'd1);
    chk("max_error_s", 32'(error_s), 32'd1);
    send_word(16'h1111, $urandom_range(0, 3));
    send_word(16'h2222, $urandom_range(0, 3));
    send_word(16'h3333, $urandom_range(0, 3));
    @(negedge clk);
    chk("mid_nwrites", wq_b.size(), 32'd3);
    chk("mid_addr", 32'(rom_addr_b), 32'h2);
    #1 xrst = 0;
    #1 chk_reset("async");
    @(negedge clk);
    xrst = 1;
    wq_b.delete();
    @(negedge clk);
    chk("post_reset_nwrites", wq_b.size(), 32'd0);
    send_word(16'h0001, $urandom_range(0, 2));
    send_word(16'hABCD, $urandom_range(0, 2));
    chk("re_we", 32'(rom_we_b), 32'd1);
    chk("re_addr", 32'(rom_addr_b), 32'h0);
    chk("re_data", 32'(rom_wdata_b), 32'hABCD);
    @(negedge clk);
    chk("re_done", {29'd0, busy_b, done_b, error_b}, 32'd2);
    chk("re_nwrites", wq_b.size(), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
